// File: rtl/sop_chain_accum_requant.sv
// SOP chain accumulator: sums 37-bit chain beats per packet, requantizes (shift + clamp) and buffers results in a small FIFO.
// Optional SOP_ROUND_NEAREST_EN selects round-half-up before the shift instead of floor.
module sop_chain_accum_requant #(
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [36:0]                   in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_err,
  output logic                          drop_err,
  input  logic                          clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = ACC_W + 1;
  localparam logic signed [WW-1:0] MAX_V = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_V = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Handshake: input has no back-pressure (every in_valid beat is taken);
  // output transfers a word on any cycle where out_valid && out_ready.

  logic [ACC_W-1:0] acc;
  logic             first;
  logic [ACC_W-1:0] sum_q;
  logic             sum_valid;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] beat_sum;

  always_comb begin
    in_ext   = {{(ACC_W-37){in_data[36]}}, in_data};
    beat_sum = (first ? '0 : acc) + in_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      first     <= 1'b1;
      sum_q     <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid && in_last;
      if (in_valid) begin
        acc   <= beat_sum;
        first <= in_last;
        if (in_last) sum_q <= beat_sum;
      end
    end
  end

  // Requantize: one extra bit of headroom so the rounding add cannot wrap.
  logic signed [WW-1:0] wide;
  logic signed [WW-1:0] shifted;
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic [OUT_W-1:0]     q_word;

`ifdef SOP_ROUND_NEAREST_EN
  localparam logic [WW-1:0] RND = (SHIFT > 0) ? (WW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  always_comb wide = $signed({sum_q[ACC_W-1], sum_q} + RND);
`else
  always_comb wide = $signed({sum_q[ACC_W-1], sum_q});
`endif

  always_comb begin
    shifted  = wide >>> SHIFT;
    clamp_hi = shifted > MAX_V;
    clamp_lo = shifted < MIN_V;
    if (clamp_hi)      q_word = MAX_V[OUT_W-1:0];
    else if (clamp_lo) q_word = MIN_V[OUT_W-1:0];
    else               q_word = shifted[OUT_W-1:0];
  end

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             sat_set;

  always_comb begin
    full      = (count == LW'(FIFO_DEPTH));
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    push_ok   = sum_valid && (!full || pop);
    drop      = sum_valid && full && !pop;
    sat_set   = sum_valid && (clamp_hi || clamp_lo);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    fifo_level = count;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= q_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sat_err  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A set event in the same cycle as clear_err leaves the flag set.
      sat_err  <= sat_set | (sat_err & ~clear_err);
      drop_err <= drop    | (drop_err & ~clear_err);
    end
  end

endmodule
